// File: rtl/maple_pkg.sv
// rtl/maple_pkg.sv - Shared constants, state enum and helpers for the Maple port scheduler
package maple_pkg;

  localparam int MAPLE_PORTS = 4;

  typedef logic [1:0] port_idx_t;

  localparam port_idx_t PORT_A = 2'd3;
  localparam port_idx_t PORT_B = 2'd2;
  localparam port_idx_t PORT_C = 2'd1;
  localparam port_idx_t PORT_D = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GUARD
  } sched_state_t;

  // One shared counter serves both the guard gap and the watchdog.
  function automatic int cnt_width(input int guard_cycles, input int timeout_cycles);
    int m;
    m = (guard_cycles > timeout_cycles) ? guard_cycles : timeout_cycles;
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

  function automatic port_idx_t onehot_idx(input logic [MAPLE_PORTS-1:0] oh);
    port_idx_t idx;
    idx = PORT_D;
    for (int i = 0; i < MAPLE_PORTS; i++) begin
      if (oh[i]) idx = port_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/maple_port_sched_if.sv
// rtl/maple_port_sched_if.sv - Port request and shared-transceiver handshake bundle
interface maple_port_sched_if;
  import maple_pkg::*;

  logic [MAPLE_PORTS-1:0] req;
  logic [MAPLE_PORTS-1:0] port_en;
  logic                   engine_done;
  logic                   engine_err;
  logic [MAPLE_PORTS-1:0] grant;
  port_idx_t              port_sel;
  logic                   engine_start;
  logic                   engine_abort;
  logic [MAPLE_PORTS-1:0] done;
  logic [MAPLE_PORTS-1:0] err;

  modport master (
    output req, port_en, engine_done, engine_err,
    input  grant, port_sel, engine_start, engine_abort, done, err
  );

  modport slave (
    input  req, port_en, engine_done, engine_err,
    output grant, port_sel, engine_start, engine_abort, done, err
  );

endinterface

// File: rtl/maple_rr_pick.sv
// rtl/maple_rr_pick.sv - Combinational round-robin pick, searching downward from last_port-1
module maple_rr_pick
  import maple_pkg::*;
(
  input  logic [MAPLE_PORTS-1:0] eligible,
  input  port_idx_t              last_port,
  output logic [MAPLE_PORTS-1:0] pick,
  output logic                   valid
);

  port_idx_t idx;

  always_comb begin
    pick = '0;
    idx  = '0;
    // Walk farthest-first so the nearest eligible port below last_port overwrites the rest.
    for (int k = MAPLE_PORTS; k >= 1; k--) begin
      idx = last_port - port_idx_t'(k);
      if (eligible[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

  assign valid = |eligible;

endmodule

// File: rtl/maple_port_sched.sv
// rtl/maple_port_sched.sv - Round-robin scheduler sharing one Maple transceiver across four ports
// Optional watchdog abort in WAIT: define MAPLE_SCHED_TIMEOUT_EN.
module maple_port_sched
  import maple_pkg::*;
#(
  parameter int GUARD_CYCLES   = 100,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic               clk,
  input logic               rst,
  maple_port_sched_if.slave bus
);

  localparam int CNT_W = cnt_width(GUARD_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  sched_state_t           state_q, state_d;
  logic [MAPLE_PORTS-1:0] grant_q, grant_d;
  port_idx_t              port_sel_q, port_sel_d;
  port_idx_t              last_q, last_d;
  logic                   start_q, start_d;
  logic [MAPLE_PORTS-1:0] done_q, done_d;
  logic [MAPLE_PORTS-1:0] err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   wait_end;
  logic [MAPLE_PORTS-1:0] pick;
  logic                   pick_valid;

`ifdef MAPLE_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  logic abort_q, abort_d;
`endif

  maple_rr_pick u_rr_pick (
    .eligible  (bus.req & bus.port_en),
    .last_port (last_q),
    .pick      (pick),
    .valid     (pick_valid)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    port_sel_d = port_sel_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    start_d    = 1'b0;
    done_d     = '0;
    err_d      = '0;
    wait_end   = 1'b0;
`ifdef MAPLE_SCHED_TIMEOUT_EN
    abort_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          grant_d    = pick;
          port_sel_d = onehot_idx(pick);
          start_d    = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion is keyed to the latched grant, so req/port_en changes here are ignored.
        if (bus.engine_done) begin
          done_d   = grant_q;
          err_d    = bus.engine_err ? grant_q : '0;
          wait_end = 1'b1;
        end
`ifdef MAPLE_SCHED_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          abort_d  = 1'b1;
          done_d   = grant_q;
          err_d    = grant_q;
          wait_end = 1'b1;
        end
`endif
        else begin
          cnt_d = sat_inc(cnt_q);
        end
        if (wait_end) begin
          grant_d = '0;
          last_d  = port_sel_q;
          cnt_d   = '0;
          state_d = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      port_sel_q <= PORT_D;
      last_q     <= PORT_D;
      start_q    <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
      cnt_q      <= '0;
`ifdef MAPLE_SCHED_TIMEOUT_EN
      abort_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      port_sel_q <= port_sel_d;
      last_q     <= last_d;
      start_q    <= start_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
`ifdef MAPLE_SCHED_TIMEOUT_EN
      abort_q    <= abort_d;
`endif
    end
  end

  assign bus.grant        = grant_q;
  assign bus.port_sel     = port_sel_q;
  assign bus.engine_start = start_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
`ifdef MAPLE_SCHED_TIMEOUT_EN
  assign bus.engine_abort = abort_q;
`else
  assign bus.engine_abort = 1'b0;
`endif

endmodule

// File: tb/tb_maple_port_sched.sv
// tb/tb_maple_port_sched.sv - Directed plus randomized checks of maple_port_sched against a reference model
module tb_maple_port_sched;

  localparam int GUARD = 100;
  localparam int TO    = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   last_model  = 0;

  maple_port_sched_if bus();

  maple_port_sched #(
    .GUARD_CYCLES   (GUARD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Next port strictly below the last served one, wrapping 0 -> 3.
  function automatic int model_pick(input logic [3:0] elig, input int last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last - k + 8) % 4;
      if (elig[i]) return i;
    end
    return -1;
  endfunction

  task automatic guard_phase(input bit spur);
    bit bad;
    bad = 1'b0;
    if (spur) bus.req = 4'b0;
    for (int i = 1; i <= GUARD; i++) begin
      if (spur && i == 3) begin
        bus.engine_done = 1'b1;
        bus.engine_err  = 1'b1;
      end
      step();
      bus.engine_done = 1'b0;
      bus.engine_err  = 1'b0;
      if (bus.grant !== 4'b0 || bus.done !== 4'b0 || bus.err !== 4'b0 ||
          bus.engine_start !== 1'b0 || bus.engine_abort !== 1'b0) bad = 1'b1;
    end
    chk("guard_quiet", 32'(bad), 32'(0));
    if (spur) begin
      bus.engine_done = 1'b1;
      bus.engine_err  = 1'b1;
      step();
      bus.engine_done = 1'b0;
      bus.engine_err  = 1'b0;
      chk("idle_spurious_done", 32'({bus.grant, bus.done, bus.err}), 32'(0));
    end
  endtask

  task automatic start_phase(input logic [3:0] rq, input logic [3:0] en, output int idx,
                             output logic [3:0] oh);
    idx = model_pick(rq & en, last_model);
    oh  = 4'(1 << idx);
    bus.req     = rq;
    bus.port_en = en;
    step();
    chk("start", 32'({bus.grant, bus.port_sel, bus.engine_start, bus.engine_abort, bus.done}),
        32'({oh, 2'(idx), 1'b1, 1'b0, 4'b0}));
  endtask

  task automatic txn(input logic [3:0] rq, input logic [3:0] en, input int dly,
                     input bit e, input bit drop, input bit spur);
    int         idx;
    logic [3:0] oh;
    bit         bad;
    start_phase(rq, en, idx, oh);
    if (drop) begin
      bus.req     = 4'b0;
      bus.port_en = 4'b0;
    end
    step();
    chk("wait1", 32'({bus.grant, bus.engine_start}), 32'({oh, 1'b0}));
    bad = 1'b0;
    for (int n = 2; n <= dly; n++) begin
      step();
      if (bus.grant !== oh || bus.done !== 4'b0) bad = 1'b1;
    end
    chk("wait_hold", 32'(bad), 32'(0));
    bus.engine_done = 1'b1;
    bus.engine_err  = e;
    step();
    bus.engine_done = 1'b0;
    bus.engine_err  = 1'b0;
    chk("done", 32'({bus.grant, bus.done, bus.err, bus.engine_abort}),
        32'({4'b0, oh, (e ? oh : 4'b0), 1'b0}));
    last_model = idx;
    guard_phase(spur);
  endtask

  task automatic timeout_txn();
    int         idx;
    logic [3:0] oh;
    bit         bad;
    start_phase(4'b0100, 4'hF, idx, oh);
    bus.req = 4'b0;
    bad = 1'b0;
`ifdef MAPLE_SCHED_TIMEOUT_EN
    for (int n = 1; n <= TO; n++) begin
      step();
      if (bus.grant !== oh || bus.engine_abort !== 1'b0 || bus.done !== 4'b0) bad = 1'b1;
    end
    chk("timeout_wait", 32'(bad), 32'(0));
    step();
    chk("timeout_abort", 32'({bus.grant, bus.engine_abort, bus.done, bus.err}),
        32'({4'b0, 1'b1, oh, oh}));
`else
    for (int n = 1; n <= 3 * TO; n++) begin
      step();
      if (bus.grant !== oh || bus.engine_abort !== 1'b0 || bus.done !== 4'b0) bad = 1'b1;
    end
    chk("no_timeout_hold", 32'(bad), 32'(0));
    bus.engine_done = 1'b1;
    step();
    bus.engine_done = 1'b0;
    chk("late_done", 32'({bus.grant, bus.done, bus.err}), 32'({4'b0, oh, 4'b0}));
`endif
    last_model = idx;
    guard_phase(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 4'b0;
    bus.port_en = 4'b0;
    bus.engine_done = 1'b0;
    bus.engine_err = 1'b0;
    step();
    step();
    rst = 1'b0;
    last_model = 0;
  endtask

  initial begin
    int         idx;
    logic [3:0] oh;
    logic [3:0] rq, en;
    bus.req = 4'b0;
    bus.port_en = 4'b0;
    bus.engine_done = 1'b0;
    bus.engine_err = 1'b0;
    step();
    step();
    chk("rst_grant", 32'(bus.grant), 32'(0));
    chk("rst_port_sel", 32'(bus.port_sel), 32'(0));
    chk("rst_pulses", 32'({bus.engine_start, bus.engine_abort, bus.done, bus.err}), 32'(0));
    rst = 1'b0;
    last_model = 0;

    txn(4'b1000, 4'hF, 10, 1'b0, 1'b0, 1'b0);
    txn(4'b0001, 4'hF, 4, 1'b1, 1'b0, 1'b1);
    txn(4'b0110, 4'b0010, 6, 1'b0, 1'b1, 1'b0);
    txn(4'b0110, 4'b0010, 2, 1'b1, 1'b0, 1'b0);

    do_reset();
    for (int t = 0; t < 8; t++) begin
      txn(4'hF, 4'hF, int'($urandom_range(1, 15)), 1'b0, 1'b0, 1'b0);
    end

    timeout_txn();

    start_phase(4'hF, 4'hF, idx, oh);
    for (int n = 1; n <= 5; n++) step();
    #3 rst = 1'b1;
    #1;
    chk("async_rst_grant", 32'({bus.grant, bus.done, bus.engine_abort}), 32'(0));
    step();
    chk("rst_no_pulse", 32'({bus.grant, bus.done, bus.err, bus.engine_abort}), 32'(0));
    rst = 1'b0;
    last_model = 0;
    txn(4'hF, 4'hF, 3, 1'b0, 1'b0, 1'b0);
    chk("first_after_rst_is_a", 32'(last_model), 32'(3));

    for (int t = 0; t < 10; t++) begin
      do begin
        rq = 4'($urandom_range(1, 15));
        en = 4'($urandom_range(1, 15));
      end while ((rq & en) == 4'b0);
      txn(rq, en, int'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/maple_port_sched.md
MAPLE_PORT_SCHED -- requirements
Module: maple_port_sched

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 100: idle bus cycles enforced after each transaction.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: engine watchdog limit in clk cycles.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  4  per-port transaction request; bit 3 = port A ... bit 0 = port D.
REQ-006 SHALL have port port_en  input  4  per-port enable mask; a masked port is never granted.
REQ-007 SHALL have port engine_done  input  1  one-cycle pulse from the shared Maple transceiver at transaction end.
REQ-008 SHALL have port engine_err  input  1  transceiver error flag, valid only with engine_done.
REQ-009 SHALL have port grant  output  4  one-hot grant of the shared transceiver to a port.
REQ-010 SHALL have port port_sel  output  2  binary index of the granted port (3 = A, 0 = D).
REQ-011 SHALL have port engine_start  output  1  one-cycle start pulse to the transceiver.
REQ-012 SHALL have port engine_abort  output  1  one-cycle abort pulse to the transceiver.
REQ-013 SHALL have port done  output  4  one-cycle per-port completion pulse.
REQ-014 SHALL have port err  output  4  per-port error pulse, coincident with done.

Function
REQ-015 SHALL implement the states IDLE, START, WAIT and GUARD.
REQ-016 IDLE: when (req & port_en) != 0, SHALL select the first eligible port in round-robin order, starting at last_port-1 and wrapping 0->3; then go to START.
REQ-017 START: grant, port_sel and engine_start SHALL be registered and asserted one cycle after the qualifying req; engine_start SHALL be high for exactly this one cycle; then go to WAIT.
REQ-018 WAIT: grant SHALL be held; on engine_done, SHALL pulse done[sel] and err[sel]=engine_err, update last_port, and go to GUARD.
REQ-019 GUARD: grant SHALL be 0; SHALL count GUARD_CYCLES cycles and then go to IDLE; with GUARD_CYCLES=0, SHALL go directly to IDLE.
REQ-020 Deassertion of req or port_en during START/WAIT SHALL NOT abort the transaction.
REQ-021 engine_done received outside WAIT SHALL be ignored.
REQ-022 grant SHALL never be more than one-hot; port_sel SHALL equal the index of grant whenever grant != 0.
REQ-023 A port with req held continuously SHALL be re-granted no sooner than after every other requesting port has been served once.
REQ-024 Counter width SHALL be $clog2(max(GUARD_CYCLES, TIMEOUT_CYCLES)+1); counters SHALL saturate and never wrap.

Reset
REQ-025 While rst=1: state=IDLE, grant=0, port_sel=0, engine_start=0, engine_abort=0, done=0, err=0, counters=0, last_port=0 (so port A, index 3, is served first).
REQ-026 Reset asserted mid-transaction SHALL drop grant immediately, with no done or abort pulse.

Configuration
REQ-027 With MAPLE_SCHED_TIMEOUT_EN defined: if WAIT lasts TIMEOUT_CYCLES cycles without engine_done, SHALL pulse engine_abort, done[sel] and err[sel] together, then go to GUARD.
REQ-028 Without MAPLE_SCHED_TIMEOUT_EN: WAIT SHALL exit only on engine_done, and engine_abort SHALL be tied to 0.

Structure
REQ-029 Package maple_pkg SHALL hold MAPLE_PORTS=4, the port index constants PORT_A..PORT_D, and the scheduler state enum.
REQ-030 The round-robin selection SHALL be the combinational sub-module maple_rr_pick (inputs: eligible mask and last_port; outputs: one-hot pick and valid).

Verification
REQ-031 req=4'b1000, port_en=4'hF; done at WAIT cycle 10 -> grant=4'b1000 and engine_start 1 cycle after req; done[3] pulse; grant=0 for 100 cycles.
REQ-032 req=4'hF held, 8 transactions -> grant order A,B,C,D,A,B,C,D (port_sel 3,2,1,0,3,2,1,0).
REQ-033 req=4'b0110, port_en=4'b0010 -> only grant=4'b0010 ever seen.
REQ-034 TIMEOUT_CYCLES=20 with macro, no engine_done -> engine_abort, done and err pulse on WAIT cycle 20; same bench without macro -> stays in WAIT indefinitely.
REQ-035 rst asserted at WAIT cycle 5 -> grant=0 asynchronously, no done pulse; after release, first grant goes to port A.
REQ-036 engine_done and engine_err pulsed in IDLE/GUARD -> no done or err output; engine_err=1 with done in WAIT -> err[sel]=1.
